fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the async FIFO write domain among N requesters. It issues burst-locked grants, muxes the granted requester's data onto the FIFO write port, and stalls on the write-side full flag. It sits in the write clock domain, directly upstream of the FIFO write-pointer/full logic.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked arbiter for the single write port
// of an async FIFO. Lives in the write clock domain. The granted requester's
// data is muxed onto the FIFO write port, and the arbiter stalls while the
// FIFO is full.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   w_clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_last,
    input  logic [N*WIDTH-1:0]     req_data,
    output logic [N-1:0]           req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_rq,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   grant_valid,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic [7:0]             full_stall_cnt
);

    localparam int IDW = $clog2(N);
    localparam int BW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state_reg;
    logic             grant_valid_reg;
    logic [IDW-1:0]   grant_id_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [BW-1:0]    beat_cnt_reg;
    logic [7:0]       full_stall_cnt_reg;

    logic [WIDTH-1:0] data_arr [N];
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic [BW-1:0]    beat_inc;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   scan_idx;

    // Split the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign sel_valid = req_valid[grant_id_reg];
    assign sel_last  = req_last[grant_id_reg];
    assign sel_data  = data_arr[grant_id_reg];
    assign accept    = (state_reg == ST_BURST) & sel_valid & ~fifo_full;
    assign beat_inc  = beat_cnt_reg + BW'(1);

    // Round-robin search: scan from the highest offset down so the requester
    // closest to rr_ptr (offset 0 first) is the one that sticks.
    always_comb begin
        winner   = rr_ptr_reg;
        scan_idx = rr_ptr_reg;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_reg + IDW'(k);
            if (req_valid[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Arbitration FSM: IDLE picks a winner, BURST holds it until last,
    // MAX_BURST beats, or the requester drops valid.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            grant_valid_reg    <= 1'b0;
            grant_id_reg       <= '0;
            rr_ptr_reg         <= '0;
            beat_cnt_reg       <= '0;
            full_stall_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_id_reg    <= winner;
                        beat_cnt_reg    <= '0;
                        grant_valid_reg <= 1'b1;
                        state_reg       <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!sel_valid) begin
                        // Requester released the grant; nothing written.
                        state_reg       <= ST_IDLE;
                        grant_valid_reg <= 1'b0;
                        rr_ptr_reg      <= grant_id_reg + IDW'(1);
                    end else if (fifo_full) begin
                        // Hold the grant indefinitely; only count the stall.
                        if (full_stall_cnt_reg != 8'hFF) begin
                            full_stall_cnt_reg <= full_stall_cnt_reg + 8'd1;
                        end
                    end else begin
                        beat_cnt_reg <= beat_inc;
                        if (sel_last || (beat_inc == BW'(MAX_BURST))) begin
                            state_reg       <= ST_IDLE;
                            grant_valid_reg <= 1'b0;
                            rr_ptr_reg      <= grant_id_reg + IDW'(1);
                        end
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Write-port mux and ready steering, combinational from registered grant.
    always_comb begin
        req_ready  = '0;
        fifo_wr_rq = 1'b0;
        fifo_wdata = '0;
        if (state_reg == ST_BURST) begin
            req_ready[grant_id_reg] = ~fifo_full;
            fifo_wr_rq              = accept;
            if (accept) begin
                fifo_wdata = sel_data;
            end
        end
    end

    assign grant_valid    = grant_valid_reg;
    assign grant_id       = grant_id_reg;
    assign full_stall_cnt = full_stall_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a vector table, hand-written corner
// sequences and random traffic checked against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 4;
    localparam int N         = 4;
    localparam int MAX_BURST = 4;

    logic                 w_clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_last;
    logic [N*WIDTH-1:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_rq;
    logic [WIDTH-1:0]     fifo_wdata;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic [7:0]           full_stall_cnt;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_BURST(MAX_BURST)) dut (
        .w_clk          (w_clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_wr_rq     (fifo_wr_rq),
        .fifo_wdata     (fifo_wdata),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .full_stall_cnt (full_stall_cnt)
    );

    always #5 w_clk = ~w_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    // Behavioural model state (plain integers).
    bit m_busy;
    int m_g, m_rr, m_beats, m_stall;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [15:0] data;
        logic        full;
        logic        exp_wr;
        logic [3:0]  exp_wdata;
        logic [3:0]  exp_ready;
        logic        exp_gv;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_rr = 0; m_beats = 0; m_stall = 0;
    endtask

    // One cycle: compare against model before the edge, then advance model.
    task automatic step();
        logic [3:0] e_ready;
        logic       e_wr;
        logic [3:0] e_wd;
        bit         found;
        int         idx;
        #1;
        e_ready = '0; e_wr = 1'b0; e_wd = '0;
        if (m_busy) begin
            if (!fifo_full) e_ready[m_g] = 1'b1;
            e_wr = req_valid[m_g] && !fifo_full;
            if (e_wr) e_wd = req_data[m_g*WIDTH +: WIDTH];
        end
        chk("m_grant_valid", {31'd0, grant_valid}, {31'd0, m_busy});
        chk("m_grant_id", {30'd0, grant_id}, m_g);
        chk("m_req_ready", {28'd0, req_ready}, {28'd0, e_ready});
        chk("m_fifo_wr_rq", {31'd0, fifo_wr_rq}, {31'd0, e_wr});
        chk("m_fifo_wdata", {28'd0, fifo_wdata}, {28'd0, e_wd});
        chk("m_stall_cnt", {24'd0, full_stall_cnt}, m_stall);
        if (fifo_full) chk("no_write_when_full", {31'd0, fifo_wr_rq}, 32'd0);
        if (fifo_wr_rq === 1'b1) wr_cnt++;
        $display("cyc t=%0t valid=%b last=%b full=%b -> gv=%b gid=%0d rdy=%b wr=%b wd=%0h stall=%0d",
                 $time, req_valid, req_last, fifo_full, grant_valid, grant_id,
                 req_ready, fifo_wr_rq, fifo_wdata, full_stall_cnt);
        @(posedge w_clk);
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1; m_g = idx; m_busy = 1; m_beats = 0;
                end
            end
        end else if (!req_valid[m_g]) begin
            m_busy = 0; m_rr = (m_g + 1) % N;
        end else if (fifo_full) begin
            if (m_stall < 255) m_stall++;
        end else begin
            m_beats++;
            if (req_last[m_g] || m_beats == MAX_BURST) begin
                m_busy = 0; m_rr = (m_g + 1) % N;
            end
        end
        @(negedge w_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge w_clk);
        @(negedge w_clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic [15:0] d, input logic f);
        req_valid = v; req_last = l; req_data = d; fifo_full = f;
    endtask

    int grants [$];
    int wr20;
    bit prev_gv;

    initial begin
        rst = 1'b1;
        drive(4'b0, 4'b0, 16'h0, 1'b0);
        model_reset();

        vecs[0]  = '{4'b0001, 4'b0000, 16'h0001, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 4'b0000, 16'h0001, 1'b0, 1'b1, 4'h1, 4'b0001, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 4'b0000, 16'h0002, 1'b0, 1'b1, 4'h2, 4'b0001, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 4'b0001, 16'h0003, 1'b0, 1'b1, 4'h3, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 2'd0};
        vecs[5]  = '{4'b1001, 4'b0000, 16'h7000, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 2'd0};
        vecs[6]  = '{4'b1001, 4'b1000, 16'h7000, 1'b0, 1'b1, 4'h7, 4'b1000, 1'b1, 2'd3};
        vecs[7]  = '{4'b0001, 4'b0000, 16'h0005, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 2'd3};
        vecs[8]  = '{4'b0001, 4'b0000, 16'h0005, 1'b1, 1'b0, 4'h0, 4'b0000, 1'b1, 2'd0};
        vecs[9]  = '{4'b0001, 4'b0001, 16'h0005, 1'b0, 1'b1, 4'h5, 4'b0001, 1'b1, 2'd0};
        vecs[10] = '{4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 2'd0};

        // Reset state
        #1;
        chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_stall_cnt", {24'd0, full_stall_cnt}, 32'd0);
        chk("rst_wr_rq", {31'd0, fifo_wr_rq}, 32'd0);
        @(negedge w_clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
            #1;
            chk($sformatf("vec%0d_wr", i), {31'd0, fifo_wr_rq}, {31'd0, vecs[i].exp_wr});
            chk($sformatf("vec%0d_wdata", i), {28'd0, fifo_wdata}, {28'd0, vecs[i].exp_wdata});
            chk($sformatf("vec%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_gv", i), {31'd0, grant_valid}, {31'd0, vecs[i].exp_gv});
            chk($sformatf("vec%0d_gid", i), {30'd0, grant_id}, {30'd0, vecs[i].exp_gid});
            step();
        end
        chk("vec_stall_cnt", {24'd0, full_stall_cnt}, 32'd1);

        // All four requesting continuously, no last
        do_reset();
        drive(4'b1111, 4'b0000, 16'h4321, 1'b0);
        wr_cnt = 0; prev_gv = 0; grants.delete(); wr20 = 0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (i == 19) wr20 = wr_cnt;
            if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
            prev_gv = grant_valid;
        end
        chk("rr4_writes_in_20", wr20, 32'd16);
        chk("rr4_num_grants", grants.size(), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk($sformatf("rr4_grant%0d", i), grants[i], i % 4);

        // fifo_full for 3 cycles mid-burst of requester 2
        do_reset();
        wr_cnt = 0;
        drive(4'b0100, 4'b0000, 16'h0A00, 1'b0);
        step(); step(); step();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_wr_rq", {31'd0, fifo_wr_rq}, 32'd0);
            chk("full_ready2", {31'd0, req_ready[2]}, 32'd0);
            chk("full_gid", {30'd0, grant_id}, 32'd2);
            step();
        end
        fifo_full = 1'b0;
        step(); step();
        chk("full_stall_3", {24'd0, full_stall_cnt}, 32'd3);
        chk("full_writes_4", wr_cnt, 32'd4);
        chk("full_burst_done", {31'd0, grant_valid}, 32'd0);

        // Saturating stall counter, no writes
        do_reset();
        wr_cnt = 0;
        drive(4'b0001, 4'b0000, 16'h000F, 1'b1);
        for (int i = 0; i < 301; i++) step();
        chk("sat_stall_255", {24'd0, full_stall_cnt}, 32'd255);
        chk("sat_no_writes", wr_cnt, 32'd0);

        // Async reset mid-burst, no clock edge
        drive(4'b1111, 4'b0000, 16'h1234, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gv", {31'd0, grant_valid}, 32'd0);
        chk("arst_wr", {31'd0, fifo_wr_rq}, 32'd0);
        chk("arst_ready", {28'd0, req_ready}, 32'd0);
        chk("arst_wdata", {28'd0, fifo_wdata}, 32'd0);
        chk("arst_stall", {24'd0, full_stall_cnt}, 32'd0);
        chk("arst_gid", {30'd0, grant_id}, 32'd0);
        model_reset();
        @(negedge w_clk);
        rst = 1'b0;

        // Requester 1 granted first, drops after 2 beats, 3 waiting
        drive(4'b1010, 4'b0000, 16'h9050, 1'b0);
        step();
        chk("drop_first_gid", {30'd0, grant_id}, 32'd1);
        step(); step();
        req_valid = 4'b1000;
        #1;
        chk("drop_no_write", {31'd0, fifo_wr_rq}, 32'd0);
        step();
        chk("drop_idle", {31'd0, grant_valid}, 32'd0);
        step();
        chk("drop_next_gid", {30'd0, grant_id}, 32'd3);
        chk("drop_next_gv", {31'd0, grant_valid}, 32'd1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req_valid = 4'($urandom);
            for (int b = 0; b < N; b++) req_last[b] = ($urandom_range(0, 3) == 0);
            req_data  = 16'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
